// File: rtl/nv_ram_rws_param.sv
// ---------------------------------------------------------------------------
// nv_ram_rws_param
//   Parameterised single-clock RAM model with one read port and one write
//   port. Writes are lane-masked. Reads have a 1- or 2-cycle latency,
//   selected by OUT_REG, and produce a one-cycle dout_vld pulse per read.
//
// Optional feature (compile-time macro):
//   NV_RAM_RWS_PARAM_BYPASS_EN
//     undefined : a read and a write to the same address in the same cycle
//                 return the word as it was before the write.
//     defined   : the same case returns the word as it is after the write
//                 (masked lanes from di, the other lanes from the array).
//                 Read latency does not change.
//
// Parameters:
//   AW      : address width
//   DEPTH   : number of words (2 .. 2**AW)
//   DW      : data width (must be divisible by MW)
//   MW      : write-mask width; each bit covers DW/MW data bits (one lane)
//   OUT_REG : 0 = 1-cycle read latency, 1 = 2-cycle read latency
//
// Ports:
//   nvdla_core_clk  : clock; all state updates on its rising edge
//   nvdla_core_rstn : asynchronous active-low reset (read pipeline only)
//   ra, re          : read address and read enable
//   dout, dout_vld  : read data and its one-cycle valid pulse
//   wa, we          : write address and write enable
//   wmask           : per-lane write enable
//   di              : write data
//   pwrbus_ram_pd   : power-down control; no functional effect here
// ---------------------------------------------------------------------------
module nv_ram_rws_param #(
  parameter int AW      = 8,
  parameter int DEPTH   = 256,
  parameter int DW      = 512,
  parameter int MW      = 8,
  parameter int OUT_REG = 1
) (
  input  logic          nvdla_core_clk,
  input  logic          nvdla_core_rstn,
  input  logic [AW-1:0] ra,
  input  logic          re,
  output logic [DW-1:0] dout,
  output logic          dout_vld,
  input  logic [AW-1:0] wa,
  input  logic          we,
  input  logic [MW-1:0] wmask,
  input  logic [DW-1:0] di,
  input  logic [31:0]   pwrbus_ram_pd
);

  localparam int LW = DW / MW;
  localparam int IW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  // AW+1 bits so that DEPTH == 2**AW is representable
  localparam logic [AW:0] DEPTH_LIM = DEPTH[AW:0];

  // Storage carries no reset: its contents survive nvdla_core_rstn.
  logic [DW-1:0] mem [DEPTH];

  logic          ra_ok;
  logic          wa_ok;
  logic [IW-1:0] ra_idx;
  logic [IW-1:0] wa_idx;
  logic [DW-1:0] rd_word;
  logic          s1_vld;
  logic [DW-1:0] s1_data;

  // The power-down bus is accepted for interface compatibility only.
  logic unused_pwrbus;
  assign unused_pwrbus = ^pwrbus_ram_pd;

  // Addresses at or above DEPTH are out of range: writes to them are dropped
  // and reads from them return zero.
  assign ra_ok  = ({1'b0, ra} < DEPTH_LIM);
  assign wa_ok  = ({1'b0, wa} < DEPTH_LIM);
  assign ra_idx = ra[IW-1:0];
  assign wa_idx = wa[IW-1:0];

  // Lane-masked write. A zero mask naturally leaves the word untouched.
  always_ff @(posedge nvdla_core_clk) begin
    if (we && wa_ok) begin
      for (int k = 0; k < MW; k++) begin
        if (wmask[k]) begin
          mem[wa_idx][k*LW +: LW] <= di[k*LW +: LW];
        end
      end
    end
  end

  // Word seen by a read sampled at this edge. Because the array is updated
  // with non-blocking assignments, the plain path is read-before-write; the
  // bypass build merges the colliding write lanes in explicitly.
  always_comb begin
    rd_word = '0;
    if (ra_ok) begin
      rd_word = mem[ra_idx];
    end
`ifdef NV_RAM_RWS_PARAM_BYPASS_EN
    if (ra_ok && we && (wa == ra)) begin
      for (int k = 0; k < MW; k++) begin
        if (wmask[k]) begin
          rd_word[k*LW +: LW] = di[k*LW +: LW];
        end
      end
    end
`endif
  end

  // First read stage: the word is captured at the edge where re is seen, so
  // a write in a later cycle cannot disturb a read already accepted. Data
  // only moves on a read, which keeps the last result on dout.
  always_ff @(posedge nvdla_core_clk or negedge nvdla_core_rstn) begin
    if (!nvdla_core_rstn) begin
      s1_vld  <= 1'b0;
      s1_data <= '0;
    end else begin
      s1_vld <= re;
      if (re) begin
        s1_data <= rd_word;
      end
    end
  end

  generate
    if (OUT_REG != 0) begin : g_out_reg
      logic          s2_vld;
      logic [DW-1:0] s2_data;

      // Optional output stage adding one cycle of latency at full throughput.
      always_ff @(posedge nvdla_core_clk or negedge nvdla_core_rstn) begin
        if (!nvdla_core_rstn) begin
          s2_vld  <= 1'b0;
          s2_data <= '0;
        end else begin
          s2_vld <= s1_vld;
          if (s1_vld) begin
            s2_data <= s1_data;
          end
        end
      end

      assign dout     = s2_data;
      assign dout_vld = s2_vld;
    end else begin : g_no_out_reg
      assign dout     = s1_data;
      assign dout_vld = s1_vld;
    end
  endgenerate

endmodule

// File: tb/tb_nv_ram_rws_param.sv
// ---------------------------------------------------------------------------
// tb_nv_ram_rws_param
//   Scoreboard bench for nv_ram_rws_param (DEPTH=200 so out-of-range
//   addresses exist, OUT_REG=1). Every accepted read pushes its expected
//   word and due cycle; the monitor pops and compares on dout_vld.
// ---------------------------------------------------------------------------
module tb_nv_ram_rws_param;

  localparam int AW      = 8;
  localparam int DEPTH   = 200;
  localparam int DW      = 512;
  localparam int MW      = 8;
  localparam int OUT_REG = 1;
  localparam int LW      = DW / MW;

  logic          clk = 1'b0;
  logic          rstn;
  logic [AW-1:0] ra;
  logic          re;
  logic [DW-1:0] dout;
  logic          dout_vld;
  logic [AW-1:0] wa;
  logic          we;
  logic [MW-1:0] wmask;
  logic [DW-1:0] di;
  logic [31:0]   pd;

  typedef struct {
    logic [DW-1:0] data;
    int            due;
  } exp_t;

  exp_t          sb[$];
  exp_t          monE;
  logic [DW-1:0] model [DEPTH];
  logic [DW-1:0] wrData [10];
  logic [DW-1:0] heldExp;
  int            checks   = 0;
  int            failures = 0;
  int            cyc      = 0;

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  nv_ram_rws_param #(
    .AW(AW), .DEPTH(DEPTH), .DW(DW), .MW(MW), .OUT_REG(OUT_REG)
  ) dut (
    .nvdla_core_clk (clk),
    .nvdla_core_rstn(rstn),
    .ra             (ra),
    .re             (re),
    .dout           (dout),
    .dout_vld       (dout_vld),
    .wa             (wa),
    .we             (we),
    .wmask          (wmask),
    .di             (di),
    .pwrbus_ram_pd  (pd)
  );

  // Single comparison point: counts every check and reports mismatches.
  task automatic checkOutput(input string tag, input logic [DW-1:0] obs,
                             input logic [DW-1:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("[TB] FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [DW-1:0] merge(input logic [DW-1:0] old,
                                          input logic [DW-1:0] d,
                                          input logic [MW-1:0] m);
    logic [DW-1:0] r;
    r = old;
    for (int k = 0; k < MW; k++) begin
      if (m[k]) r[k*LW +: LW] = d[k*LW +: LW];
    end
    return r;
  endfunction

  function automatic logic [DW-1:0] randWord();
    logic [DW-1:0] v;
    for (int i = 0; i < DW / 32; i++) v[i*32 +: 32] = $urandom();
    return v;
  endfunction

  // Drives one cycle of inputs and updates the reference model. The read's
  // expectation is taken before the write is applied to the model.
  task automatic applyStimulus(input logic r, input logic [AW-1:0] rAddr,
                               input logic w, input logic [AW-1:0] wAddr,
                               input logic [MW-1:0] m, input logic [DW-1:0] d);
    exp_t          e;
    logic [DW-1:0] rd;
    @(negedge clk);
    re = r; ra = rAddr; we = w; wa = wAddr; wmask = m; di = d;
    if (r) begin
      if (int'(rAddr) >= DEPTH) rd = '0;
      else                      rd = model[rAddr];
`ifdef NV_RAM_RWS_PARAM_BYPASS_EN
      if (w && (wAddr == rAddr) && (int'(wAddr) < DEPTH)) rd = merge(rd, d, m);
`endif
      e.data = rd;
      e.due  = cyc + 1 + OUT_REG;
      sb.push_back(e);
    end
    if (w && (int'(wAddr) < DEPTH)) model[wAddr] = merge(model[wAddr], d, m);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) applyStimulus(1'b0, '0, 1'b0, '0, '0, '0);
  endtask

  // Monitor: compares every dout_vld pulse against the scoreboard head and
  // flags pulses that never arrive by their due cycle.
  always @(negedge clk) begin
    if (rstn) begin
      if (dout_vld) begin
        if (sb.size() == 0) begin
          checkOutput("spurious_vld", DW'(dout_vld), '0);
        end else begin
          monE = sb.pop_front();
          checkOutput("rd_data", dout, monE.data);
          checkOutput("rd_latency", DW'(cyc), DW'(monE.due));
        end
      end else if (sb.size() > 0 && sb[0].due <= cyc) begin
        checkOutput("missing_vld", DW'(dout_vld), DW'(1));
        monE = sb.pop_front();
      end
    end
  end

  initial begin
    logic [DW-1:0] ones;
    logic [AW-1:0] rA;
    logic [AW-1:0] wA;
    ones = '1;
    re = 1'b0; ra = '0; we = 1'b0; wa = '0; wmask = '0; di = '0; pd = '0;
    rstn = 1'b1;
    #1 rstn = 1'b0;
    @(posedge clk);
    @(negedge clk);
    checkOutput("reset_dout", dout, '0);
    checkOutput("reset_vld", DW'(dout_vld), '0);
    rstn = 1'b1;

    // Full-mask write then read of the same word on the next cycle
    applyStimulus(1'b0, '0, 1'b1, 8'd3, 8'hFF, {64{8'hA5}});
    applyStimulus(1'b1, 8'd3, 1'b0, '0, '0, '0);
    idle(3);

    // Single-lane write keeps the other lanes
    applyStimulus(1'b0, '0, 1'b1, 8'd7, 8'hFF, '0);
    applyStimulus(1'b0, '0, 1'b1, 8'd7, 8'h01, ones);
    applyStimulus(1'b1, 8'd7, 1'b0, '0, '0, '0);
    idle(3);

    // Same-cycle read and write to one address
    applyStimulus(1'b0, '0, 1'b1, 8'd5, 8'hFF, {64{8'h11}});
    applyStimulus(1'b1, 8'd5, 1'b1, 8'd5, 8'hFF, {64{8'h22}});
    applyStimulus(1'b1, 8'd5, 1'b0, '0, '0, '0);
    idle(3);

    // Fill 0..9, then 10 back-to-back reads
    for (int i = 0; i < 10; i++) begin
      wrData[i] = randWord();
      applyStimulus(1'b0, '0, 1'b1, AW'(i), 8'hFF, wrData[i]);
    end
    for (int i = 0; i < 10; i++) applyStimulus(1'b1, AW'(i), 1'b0, '0, '0, '0);
    // Write to the last address read must not disturb the held dout
    applyStimulus(1'b0, '0, 1'b1, 8'd9, 8'hFF, randWord());
    idle(4);
    heldExp = wrData[9];
    checkOutput("dout_hold", dout, heldExp);

    // Read and write to different addresses together; write just after read
    applyStimulus(1'b1, 8'd2, 1'b1, 8'd4, 8'h3C, randWord());
    applyStimulus(1'b0, '0, 1'b1, 8'd2, 8'hFF, randWord());
    applyStimulus(1'b1, 8'd4, 1'b0, '0, '0, '0);
    idle(3);

    // Out-of-range write is dropped, out-of-range read returns zero
    applyStimulus(1'b0, '0, 1'b1, 8'd250, 8'hFF, ones);
    applyStimulus(1'b1, 8'd250, 1'b0, '0, '0, '0);
    applyStimulus(1'b0, '0, 1'b1, 8'd1, 8'h00, ones);
    for (int i = 0; i < 10; i++) applyStimulus(1'b1, AW'(i), 1'b0, '0, '0, '0);
    idle(3);

    // Reset mid-pipeline discards the in-flight read
    applyStimulus(1'b1, 8'd3, 1'b0, '0, '0, '0);
    @(posedge clk);
    #2;
    re = 1'b0; we = 1'b0;
    rstn = 1'b0;
    sb.delete();
    #1;
    checkOutput("rst_mid_dout", dout, '0);
    checkOutput("rst_mid_vld", DW'(dout_vld), '0);
    @(negedge clk);
    @(negedge clk);
    rstn = 1'b1;
    idle(4);
    applyStimulus(1'b1, 8'd3, 1'b0, '0, '0, '0);
    applyStimulus(1'b1, 8'd7, 1'b0, '0, '0, '0);
    idle(3);

    // Random mix over written and out-of-range addresses
    for (int i = 0; i < 60; i++) begin
      rA = ($urandom_range(0, 7) == 0) ? AW'(200 + $urandom_range(0, 55))
                                       : AW'($urandom_range(0, 9));
      wA = ($urandom_range(0, 7) == 0) ? AW'(200 + $urandom_range(0, 55))
                                       : AW'($urandom_range(0, 9));
      applyStimulus(1'($urandom_range(0, 1)), rA, 1'($urandom_range(0, 1)), wA,
                    MW'($urandom()), randWord());
    end

    for (int i = 0; i < 10 && sb.size() > 0; i++) idle(1);
    idle(1);
    checkOutput("drain_empty", DW'(sb.size()), '0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/nv_ram_rws_param.md
NV_RAM_RWS_PARAM -- requirements
Module: nv_ram_rws_param

Interface
REQ-001 SHALL provide parameter AW, default 8: read/write address width in bits.
REQ-002 SHALL provide parameter DEPTH, default 256: number of words; legal range 2..2**AW.
REQ-003 SHALL provide parameter DW, default 512: data word width in bits.
REQ-004 SHALL provide parameter MW, default 8: write-mask width; DW SHALL be divisible by MW; each mask bit covers DW/MW bits (a lane).
REQ-005 SHALL provide parameter OUT_REG, default 1: 0 gives 1-cycle read latency, 1 gives 2-cycle read latency.
REQ-006 nvdla_core_clk  input  1  sole clock; all state updates on its rising edge.
REQ-007 nvdla_core_rstn  input  1  asynchronous, active-low reset.
REQ-008 ra  input  AW  read address.
REQ-009 re  input  1  read enable.
REQ-010 dout  output  DW  read data.
REQ-011 dout_vld  output  1  one-cycle pulse marking dout as new read data.
REQ-012 wa  input  AW  write address.
REQ-013 we  input  1  write enable.
REQ-014 wmask  input  MW  per-lane write enable; bit k writes di[k*DW/MW +: DW/MW].
REQ-015 di  input  DW  write data.
REQ-016 pwrbus_ram_pd  input  32  power-down control; no functional effect on this model.

Function
REQ-017 Write SHALL occur at the clock edge where we=1 and wa<DEPTH, updating only lanes whose wmask bit is 1; unmasked lanes keep their prior contents.
REQ-018 Write with wa>=DEPTH or wmask=0 SHALL leave the array unchanged.
REQ-019 Read SHALL capture ra at the edge where re=1 (stage 1); with OUT_REG=0, dout/dout_vld SHALL update at that same edge's successor output (valid in cycle N+1); with OUT_REG=1, one further register stage SHALL delay them to cycle N+2.
REQ-020 dout_vld SHALL be 1 for exactly one cycle per accepted read; back-to-back reads (re=1 every cycle) SHALL give back-to-back dout_vld with full throughput.
REQ-021 dout SHALL hold the most recent read result when dout_vld=0; later writes to that address SHALL NOT change dout until a new read completes.
REQ-022 Read with ra>=DEPTH SHALL return all-zero dout with dout_vld=1.
REQ-023 Read of a never-written address SHALL return X in simulation; no initialisation is required.
REQ-024 Read and write to different addresses in the same cycle SHALL both complete without interaction.
REQ-025 Same-cycle read and write to the same address: behaviour per REQ-030/REQ-031.
REQ-026 Write to an address one cycle after its read is captured SHALL NOT alter that read's result.

Reset
REQ-027 On nvdla_core_rstn=0, dout_vld SHALL go to 0 and dout to all-zero immediately, and all pipeline valid/address stages SHALL clear; array contents SHALL be unaffected.
REQ-028 Reads in flight when reset asserts SHALL be discarded: no dout_vld for them after reset releases.
REQ-029 First edge after reset deassertion SHALL accept re/we normally.

Configuration
REQ-030 Without NV_RAM_RWS_PARAM_BYPASS_EN defined, a same-cycle same-address read/write SHALL return the pre-write contents (read-before-write).
REQ-031 With NV_RAM_RWS_PARAM_BYPASS_EN defined, a same-cycle same-address read/write SHALL return the post-write word: masked lanes from di, unmasked lanes from prior contents; latency unchanged.

Verification
REQ-032 Defaults, OUT_REG=1: write 0xA5..A5 to addr 3 with wmask=0xFF; read addr 3 next cycle -> dout=0xA5..A5, dout_vld high exactly 2 cycles after re.
REQ-033 Write 0 to addr 7 (full mask), then di=all-ones with wmask=0x01 to addr 7; read -> only bits[63:0] ones, rest zero.
REQ-034 Same cycle: addr 5 holds 0x11..11, write 0x22..22 full mask plus read addr 5 -> 0x11..11 without macro, 0x22..22 with NV_RAM_RWS_PARAM_BYPASS_EN.
REQ-035 re=1 for 10 consecutive cycles with ra=0..9 -> 10 consecutive dout_vld pulses, data in address order; then a write to addr 9 leaves dout unchanged.
REQ-036 DEPTH=200, AW=8: write addr 250 then read addr 250 -> dout=0, dout_vld=1; addr 0..199 unchanged.
REQ-037 Issue read, assert nvdla_core_rstn=0 for one cycle mid-pipeline -> dout=0 and dout_vld=0 immediately, no dout_vld after release; a subsequent read returns pre-reset array data.
